// File: rtl/tick_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tick_seq_pkg : shared state encoding and counter-width helper          |
// | Revision     : 1.0                                                     |
// +-----------------------------------------------------------------------+
package tick_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Never returns 0 so a modulus of 1 or 2 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mod_counter : synchronous-clear modulo-MOD counter with wrap strobe    |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
module mod_counter #(
  parameter int MOD = 2,
  parameter int W   = 1
) (
  input  logic         clk_100MHz,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] c_last = W'(MOD - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == c_last) ? '0 : r_count + W'(1);
    end
  end

  assign count = r_count;
  assign wrap  = en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/tick_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tick_sequencer : shared prescaler, free-running scan tick and a        |
// |                  run/pause/clear gated seconds channel.                |
// |                  Optional: TICK_SEQ_SINGLE_STEP_EN adds a step input.  |
// | Revision       : 1.0                                                   |
// +-----------------------------------------------------------------------+
module tick_sequencer
  import tick_seq_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int BASE_HZ  = 1000,
  parameter int SCAN_DIV = 4,
  parameter int SEC_DIV  = 1000
) (
  input  logic                            clk_100MHz,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            clear,
`ifdef TICK_SEQ_SINGLE_STEP_EN
  input  logic                            step,
`endif
  output logic                            tick_base,
  output logic                            tick_scan,
  output logic                            tick_1hz,
  output logic                            clk_1hz,
  output logic [cnt_width(SEC_DIV)-1:0]   sec_phase,
  output logic [1:0]                      state
);

  localparam int c_prescale = CLK_HZ / BASE_HZ;
  localparam int c_pre_w    = cnt_width(c_prescale);
  localparam int c_scan_w   = cnt_width(SCAN_DIV);
  localparam int c_sec_w    = cnt_width(SEC_DIV);
  localparam logic [c_sec_w-1:0] c_sec_half = c_sec_w'(SEC_DIV / 2);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_tick_base;
  logic                 r_tick_scan;
  logic                 r_tick_1hz;
  logic                 r_clk_1hz;
  logic                 w_pre_wrap;
  logic                 w_scan_wrap;
  logic                 w_sec_wrap;
  logic                 w_sec_en;
  logic                 w_step;
  logic [c_pre_w-1:0]   w_unused_pre_count;
  logic [c_scan_w-1:0]  w_unused_scan_count;
  logic [c_sec_w-1:0]   w_sec_count;
  logic [c_sec_w-1:0]   w_sec_next;

  mod_counter #(.MOD(c_prescale), .W(c_pre_w)) u_prescaler (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .clr        (1'b0),
    .en         (1'b1),
    .count      (w_unused_pre_count),
    .wrap       (w_pre_wrap)
  );

  // Enabled on the prescaler wrap so its strobe registers alongside tick_base.
  mod_counter #(.MOD(SCAN_DIV), .W(c_scan_w)) u_scan (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .clr        (1'b0),
    .en         (w_pre_wrap),
    .count      (w_unused_scan_count),
    .wrap       (w_scan_wrap)
  );

`ifdef TICK_SEQ_SINGLE_STEP_EN
  assign w_step = step && (r_state == ST_PAUSE) && !clear && !start;
`else
  assign w_step = 1'b0;
`endif

  assign w_sec_en = (r_tick_base && (r_state == ST_RUN)) || w_step;

  mod_counter #(.MOD(SEC_DIV), .W(c_sec_w)) u_seconds (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .clr        (clear),
    .en         (w_sec_en),
    .count      (w_sec_count),
    .wrap       (w_sec_wrap)
  );

  // Mirror of the seconds counter's next value so clk_1hz changes with it.
  always_comb begin
    w_sec_next = w_sec_count;
    if (clear) begin
      w_sec_next = '0;
    end else if (w_sec_en) begin
      w_sec_next = w_sec_wrap ? '0 : w_sec_count + c_sec_w'(1);
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) w_state_next = ST_RUN;
        ST_RUN:   if (stop)  w_state_next = ST_PAUSE;
        ST_PAUSE: if (start) w_state_next = ST_RUN;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      r_tick_base <= 1'b0;
      r_tick_scan <= 1'b0;
      r_tick_1hz  <= 1'b0;
      r_clk_1hz   <= 1'b0;
    end else begin
      r_tick_base <= w_pre_wrap;
      r_tick_scan <= w_scan_wrap;
      r_tick_1hz  <= w_sec_wrap && !clear;
      r_clk_1hz   <= (w_sec_next >= c_sec_half);
    end
  end

  assign tick_base = r_tick_base;
  assign tick_scan = r_tick_scan;
  assign tick_1hz  = r_tick_1hz;
  assign clk_1hz   = r_clk_1hz;
  assign sec_phase = w_sec_count;
  assign state     = r_state;

endmodule
`default_nettype wire
